// File: rtl/axi_master_bridge.sv
// axi_master_bridge: turns single CPU SRAM-style requests into AXI4 transactions, one outstanding at a time.
// Ports:
//   clk, rst (async, active-low); CPU side: CS, OE, WEB, A, DI -> DO, DO_VALID, DO_IDX, Stall, ERR.
//   AXI side: AW/W/B and AR/R channels; IDs, lengths, sizes and bursts are constants.
// Config: define AXI_POSTED_WRITE_EN to finish writes on the W handshake, collecting B in the background.
module axi_master_bridge #(
    parameter logic [3:0] MASTER_ID = 4'h0,
    parameter int         BURST_LEN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        OE,
    input  logic [3:0]  WEB,
    input  logic [31:0] A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        DO_VALID,
    output logic [3:0]  DO_IDX,
    output logic        Stall,
    output logic        ERR,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);
    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
    localparam logic [3:0] LAST = 4'(BURST_LEN - 1);
`ifdef AXI_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    state_t      state;
    logic [31:0] addr_q, wdata_q, do_q;
    logic [3:0]  wstrb_q, beat_cnt, idx_q;
    logic        err_q, req, is_wr, r_hs, w_hs, b_hs, wr_done, blk, unused;
    assign unused   = ^{RID, BID, A[1:0]};
    assign req      = CS && (WEB != 4'hF || OE);
    assign is_wr    = WEB != 4'hF;
    assign r_hs     = state == R && RVALID;
    assign w_hs     = state == W && WREADY;
    assign Stall    = state == IDLE ? req : !((r_hs && RLAST) || wr_done);
    assign ARID     = MASTER_ID;
    assign ARADDR   = addr_q;
    assign ARLEN    = LAST;
    assign ARSIZE   = 3'b010;
    assign ARBURST  = 2'b01;
    assign ARVALID  = state == AR;
    assign RREADY   = state == R;
    assign AWID     = MASTER_ID;
    assign AWADDR   = addr_q;
    assign AWLEN    = 4'd0;
    assign AWSIZE   = 3'b010;
    assign AWBURST  = 2'b01;
    assign AWVALID  = state == AW;
    assign WDATA    = wdata_q;
    assign WSTRB    = wstrb_q;
    assign WLAST    = 1'b1;
    assign WVALID   = state == W;
    assign DO_VALID = r_hs;
    assign DO       = r_hs ? RDATA : do_q;
    assign DO_IDX   = r_hs ? beat_cnt : idx_q;
    assign ERR      = err_q;
`ifdef AXI_POSTED_WRITE_EN
    // B is collected outside the FSM; new requests wait until it arrives
    logic pend_b;
    assign b_hs    = pend_b && BVALID;
    assign BREADY  = pend_b;
    assign wr_done = w_hs;
    assign blk     = pend_b;
    always_ff @(posedge clk or negedge rst)
        if (!rst) pend_b <= 1'b0;
        else pend_b <= w_hs ? 1'b1 : (b_hs ? 1'b0 : pend_b);
`else
    assign b_hs    = state == B && BVALID;
    assign BREADY  = state == B;
    assign wr_done = b_hs;
    assign blk     = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            do_q     <= '0;
            idx_q    <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req && !blk) begin
                    state    <= is_wr ? AW : AR;
                    addr_q   <= {A[31:2], 2'b00};
                    wdata_q  <= DI;
                    wstrb_q  <= ~WEB;
                    beat_cnt <= '0;
                end
                AR: if (ARREADY) state <= R;
                R: if (RVALID) begin
                    do_q     <= RDATA;
                    idx_q    <= beat_cnt;
                    beat_cnt <= beat_cnt + 4'd1;
                    if (RLAST) state <= IDLE;
                end
                AW: if (AWREADY) state <= W;
                W: if (WREADY) state <= POSTED ? IDLE : B;
                B: if (BVALID) state <= IDLE;
                default: state <= IDLE;
            endcase
            // bad response or an RLAST that arrives before the programmed length
            if ((r_hs && (RRESP != 2'b00 || (RLAST && beat_cnt < LAST))) || (b_hs && BRESP != 2'b00))
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: directed self-checking bench for axi_master_bridge (BURST_LEN=4, MASTER_ID=5).
module tb_axi_master_bridge;
`ifdef AXI_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    logic        clk, rst, CS, OE;
    logic [3:0]  WEB;
    logic [31:0] A, DI, DO;
    logic        DO_VALID, Stall, ERR;
    logic [3:0]  DO_IDX;
    logic [3:0]  AWID, AWLEN, ARID, ARLEN, WSTRB, BID, RID;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    int vectors = 0;
    int miscompares = 0;

    axi_master_bridge #(.MASTER_ID(4'h5), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI),
        .DO(DO), .DO_VALID(DO_VALID), .DO_IDX(DO_IDX), .Stall(Stall), .ERR(ERR),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [31:0] base, input int bad, input int last);
        #1 chk("r_rready", {31'b0, RREADY}, 32'd1);
        chk("r_arvalid_low", {31'b0, ARVALID}, 32'd0);
        for (int i = 0; i <= last; i++) begin
            RVALID = 1'b1;
            RDATA  = base + 32'(i);
            RLAST  = (i == last);
            RRESP  = (i == bad) ? 2'b10 : 2'b00;
            #1 chk("beat_valid", {31'b0, DO_VALID}, 32'd1);
            chk("beat_do", DO, base + 32'(i));
            chk("beat_idx", {28'b0, DO_IDX}, 32'(i));
            chk("beat_stall", {31'b0, Stall}, (i == last) ? 32'd0 : 32'd1);
            step;
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
        #1 chk("r_done_valid", {31'b0, DO_VALID}, 32'd0);
        chk("r_done_hold", DO, base + 32'(last));
        chk("r_done_rready", {31'b0, RREADY}, 32'd0);
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [31:0] base, input int ar_wait,
                            input int bad, input int last);
        CS = 1'b1; OE = 1'b1; WEB = 4'hF; A = a;
        #1 chk("rd_idle_stall", {31'b0, Stall}, 32'd1);
        step;
        CS = 1'b0; OE = 1'b0;
        #1 chk("ar_valid", {31'b0, ARVALID}, 32'd1);
        chk("ar_addr", ARADDR, a & 32'hFFFF_FFFC);
        chk("ar_stall", {31'b0, Stall}, 32'd1);
        chk("ar_awvalid_low", {31'b0, AWVALID}, 32'd0);
        for (int i = 0; i < ar_wait; i++) begin
            step;
            chk("ar_hold_valid", {31'b0, ARVALID}, 32'd1);
            chk("ar_hold_addr", ARADDR, a & 32'hFFFF_FFFC);
        end
        ARREADY = 1'b1;
        step;
        ARREADY = 1'b0;
        beats(base, bad, last);
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [3:0] web, input logic [31:0] di,
                             input logic oe, input logic [31:0] ea, input logic [3:0] es,
                             input logic bv);
        CS = 1'b1; OE = oe; WEB = web; A = a; DI = di;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = bv; BRESP = 2'b00;
        #1 chk("wr_idle_stall", {31'b0, Stall}, 32'd1);
        step;
        CS = 1'b0; OE = 1'b0; WEB = 4'hF;
        #1 chk("aw_valid", {31'b0, AWVALID}, 32'd1);
        chk("aw_addr", AWADDR, ea);
        chk("aw_arvalid_low", {31'b0, ARVALID}, 32'd0);
        chk("aw_stall", {31'b0, Stall}, 32'd1);
        step;
        #1 chk("w_valid", {31'b0, WVALID}, 32'd1);
        chk("w_data", WDATA, di);
        chk("w_strb", {28'b0, WSTRB}, {28'b0, es});
        chk("w_last", {31'b0, WLAST}, 32'd1);
        chk("w_arvalid_low", {31'b0, ARVALID}, 32'd0);
        chk("w_stall", {31'b0, Stall}, {31'b0, !POSTED});
        step;
        #1 chk("b_bready", {31'b0, BREADY}, 32'd1);
        chk("b_stall", {31'b0, Stall}, 32'd0);
        chk("b_arvalid_low", {31'b0, ARVALID}, 32'd0);
        if (bv) begin
            step;
            BVALID = 1'b0;
            #1 chk("wr_end_bready", {31'b0, BREADY}, 32'd0);
        end
        AWREADY = 1'b0; WREADY = 1'b0;
    endtask

    initial begin
        rst = 1'b0; CS = 1'b0; OE = 1'b0; WEB = 4'hF; A = '0; DI = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = 4'h3; BRESP = 2'b00; BVALID = 1'b0;
        ARREADY = 1'b0; RID = 4'h3; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
        #3;
        chk("rst_arvalid", {31'b0, ARVALID}, 32'd0);
        chk("rst_awvalid", {31'b0, AWVALID}, 32'd0);
        chk("rst_do", DO, 32'd0);
        chk("rst_err", {31'b0, ERR}, 32'd0);
        chk("rst_stall", {31'b0, Stall}, 32'd0);
        chk("rst_arlen", {28'b0, ARLEN}, 32'd3);
        chk("rst_arid", {28'b0, ARID}, 32'd5);
        chk("rst_awid", {28'b0, AWID}, 32'd5);
        chk("rst_arsize", {29'b0, ARSIZE}, 32'd2);
        chk("rst_awburst", {30'b0, AWBURST}, 32'd1);
        chk("rst_awlen", {28'b0, AWLEN}, 32'd0);
        step;
        step;
        rst = 1'b1;
        // 4-beat read with ARREADY held off for two cycles
        read_txn(32'h0000_1004, 32'h0000_00A0, 2, -1, 3);
        chk("rd_err_clean", {31'b0, ERR}, 32'd0);
        // byte-lane write, all ready
        write_txn(32'h0000_2002, 4'b1100, 32'h1234_5678, 1'b0, 32'h0000_2000, 4'b0011, 1'b1);
        // simultaneous read and write request: write wins
        write_txn(32'h0000_2108, 4'b1110, 32'hCAFE_F00D, 1'b1, 32'h0000_2108, 4'b0001, 1'b1);
        chk("prio_err_clean", {31'b0, ERR}, 32'd0);
        // error response on beat 1 is sticky
        read_txn(32'h0000_4000, 32'h0000_00B0, 0, 1, 3);
        chk("rresp_err", {31'b0, ERR}, 32'd1);
        write_txn(32'h0000_4400, 4'b0000, 32'h0BAD_CAFE, 1'b0, 32'h0000_4400, 4'b1111, 1'b1);
        chk("err_sticky", {31'b0, ERR}, 32'd1);
        // asynchronous reset in the middle of a read burst
        CS = 1'b1; OE = 1'b1; A = 32'h0000_5008;
        step;
        CS = 1'b0; OE = 1'b0; ARREADY = 1'b1;
        step;
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0000_00C0; RLAST = 1'b0;
        #1 chk("mid_beat_valid", {31'b0, DO_VALID}, 32'd1);
        step;
        rst = 1'b0;
        #1 chk("arst_rready", {31'b0, RREADY}, 32'd0);
        chk("arst_do", DO, 32'd0);
        chk("arst_do_valid", {31'b0, DO_VALID}, 32'd0);
        chk("arst_do_idx", {28'b0, DO_IDX}, 32'd0);
        chk("arst_err", {31'b0, ERR}, 32'd0);
        chk("arst_arlen", {28'b0, ARLEN}, 32'd3);
        RVALID = 1'b0;
        step;
        rst = 1'b1;
        read_txn(32'h0000_6000, 32'h0000_00D0, 0, -1, 3);
        chk("post_rst_err", {31'b0, ERR}, 32'd0);
        // RLAST on beat 1 of 4 ends the read early and flags an error
        read_txn(32'h0000_7000, 32'h0000_00E0, 0, -1, 1);
        chk("early_rlast_err", {31'b0, ERR}, 32'd1);
`ifdef AXI_POSTED_WRITE_EN
        // posted write, B withheld five cycles while a read waits in IDLE
        write_txn(32'h0000_8000, 4'b0000, 32'h5555_AAAA, 1'b0, 32'h0000_8000, 4'b1111, 1'b0);
        CS = 1'b1; OE = 1'b1; A = 32'h0000_9000;
        #1 chk("pw_idle_stall", {31'b0, Stall}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("pw_wait_arvalid", {31'b0, ARVALID}, 32'd0);
            chk("pw_wait_stall", {31'b0, Stall}, 32'd1);
            chk("pw_wait_bready", {31'b0, BREADY}, 32'd1);
        end
        BVALID = 1'b1;
        step;
        BVALID = 1'b0;
        #1 chk("pw_bready_clear", {31'b0, BREADY}, 32'd0);
        chk("pw_still_idle", {31'b0, ARVALID}, 32'd0);
        step;
        CS = 1'b0; OE = 1'b0;
        #1 chk("pw_arvalid", {31'b0, ARVALID}, 32'd1);
        chk("pw_araddr", ARADDR, 32'h0000_9000);
        ARREADY = 1'b1;
        step;
        ARREADY = 1'b0;
        beats(32'h0000_00F0, -1, 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
